cache_mem_arbiter: RTL

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Purpose  : Arbitrates a single memory port between an instruction cache and
//            a data cache. A three-state FSM (IDLE / OWN_I / OWN_D) hands
//            memory ownership to one requester at a time. Ties are broken
//            round-robin through a 1-bit last_winner register. Memory
//            responses are routed back with one cycle of latency, decoded
//            from the top two access_id bits:
//              2'b01 -> icache
//              2'b00 -> dcache
//              other -> dropped and counted
// Config   : CACHE_ARB_BURST_LOCK_EN
//              defined   : an owner keeps memory for its whole burst
//                          (access_length beats, 0 meaning 1).
//              undefined : ownership is released after every granted beat.
// Ports    : clk            - clock, rising edge
//            reset          - asynchronous, active-low reset
//            icache_req     - icache request        icache_grant - beat accepted
//            icache_rsp     - response to icache
//            dcache_req     - dcache request        dcache_grant - beat accepted
//            dcache_rsp     - response to dcache
//            mem_req        - request presented to memory
//            mem_grant      - memory accepts mem_req
//            mem_rsp        - response from memory
//            rsp_drop_count - saturating count of unroutable responses
// Revision : 1.0 - initial release
// ============================================================================

localparam int ACCESS_ID_WIDTH = 8;

typedef struct packed {
    logic                       vld;
    logic                       we;
    logic [ACCESS_ID_WIDTH-1:0] access_id;
    logic [ACCESS_ID_WIDTH-1:0] access_length;
    logic [31:0]                addr;
    logic [31:0]                data;
} request_t;

module cache_mem_arbiter #(
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  request_t                  icache_req,
    output logic                      icache_grant,
    output request_t                  icache_rsp,
    input  request_t                  dcache_req,
    output logic                      dcache_grant,
    output request_t                  dcache_rsp,
    output request_t                  mem_req,
    input  logic                      mem_grant,
    input  request_t                  mem_rsp,
    output logic [DROP_CNT_WIDTH-1:0] rsp_drop_count
);

    localparam int AW = ACCESS_ID_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_I = 2'd1,
        ST_OWN_D = 2'd2
    } state_e;

    localparam logic LW_I = 1'b0;
    localparam logic LW_D = 1'b1;

    state_e        state_q, state_d;
    logic          last_winner_q, last_winner_d;
    logic [AW-1:0] beat_cnt_q, beat_cnt_d;

    request_t      w_own_req;
    logic          w_own_is_i;
    logic          w_own_grant;
    logic          w_burst_done;
    logic [AW-1:0] w_beat_inc;

`ifdef CACHE_ARB_BURST_LOCK_EN
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] w_len;
    logic [AW-1:0] w_len_eff;
`endif

    // ------------------------------------------------------------------
    // Arbitration FSM: next state and request-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        beat_cnt_d    = beat_cnt_q;
        mem_req       = '0;
        icache_grant  = 1'b0;
        dcache_grant  = 1'b0;
        w_own_is_i    = (state_q == ST_OWN_I);
        w_own_req     = w_own_is_i ? icache_req : dcache_req;
        w_own_grant   = 1'b0;
        w_beat_inc    = beat_cnt_q + AW'(1);
`ifdef CACHE_ARB_BURST_LOCK_EN
        len_d         = len_q;
        // The first beat uses the live length; later beats the latched one.
        w_len         = (beat_cnt_q == '0) ? w_own_req.access_length : len_q;
        w_len_eff     = (w_len == '0) ? AW'(1) : w_len;
        w_burst_done  = (w_beat_inc == w_len_eff);
`else
        w_burst_done  = 1'b1;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // Counter is cleared here so every OWN state starts at zero.
                beat_cnt_d = '0;
                if (icache_req.vld && dcache_req.vld) begin
                    state_d = (last_winner_q == LW_D) ? ST_OWN_I : ST_OWN_D;
                end else if (icache_req.vld) begin
                    state_d = ST_OWN_I;
                end else if (dcache_req.vld) begin
                    state_d = ST_OWN_D;
                end
            end
            ST_OWN_I, ST_OWN_D: begin
                mem_req      = w_own_req;
                w_own_grant  = mem_grant & w_own_req.vld;
                icache_grant = w_own_grant & w_own_is_i;
                dcache_grant = w_own_grant & ~w_own_is_i;
                if (!w_own_req.vld) begin
                    // Owner withdrew mid-burst: abandon the burst.
                    state_d       = ST_IDLE;
                    last_winner_d = w_own_is_i ? LW_I : LW_D;
                end else if (w_own_grant) begin
                    beat_cnt_d = w_beat_inc;
`ifdef CACHE_ARB_BURST_LOCK_EN
                    if (beat_cnt_q == '0) begin
                        len_d = w_own_req.access_length;
                    end
`endif
                    if (w_burst_done) begin
                        state_d       = ST_IDLE;
                        last_winner_d = w_own_is_i ? LW_I : LW_D;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response routing: independent of FSM state, one cycle of latency
    // ------------------------------------------------------------------
    request_t                  icache_rsp_q, icache_rsp_d;
    request_t                  dcache_rsp_q, dcache_rsp_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [1:0]                w_rsp_prefix;

    always_comb begin
        w_rsp_prefix     = mem_rsp.access_id[AW-1 -: 2];
        icache_rsp_d     = mem_rsp;
        icache_rsp_d.vld = mem_rsp.vld && (w_rsp_prefix == 2'b01);
        dcache_rsp_d     = mem_rsp;
        dcache_rsp_d.vld = mem_rsp.vld && (w_rsp_prefix == 2'b00);
        drop_cnt_d       = drop_cnt_q;
        // Prefixes 2'b10 and 2'b11 have no destination.
        if (mem_rsp.vld && w_rsp_prefix[1] && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            last_winner_q <= LW_D;
            beat_cnt_q    <= '0;
            icache_rsp_q  <= '0;
            dcache_rsp_q  <= '0;
            drop_cnt_q    <= '0;
`ifdef CACHE_ARB_BURST_LOCK_EN
            len_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            beat_cnt_q    <= beat_cnt_d;
            icache_rsp_q  <= icache_rsp_d;
            dcache_rsp_q  <= dcache_rsp_d;
            drop_cnt_q    <= drop_cnt_d;
`ifdef CACHE_ARB_BURST_LOCK_EN
            len_q         <= len_d;
`endif
        end
    end

    assign icache_rsp     = icache_rsp_q;
    assign dcache_rsp     = dcache_rsp_q;
    assign rsp_drop_count = drop_cnt_q;

endmodule

`default_nettype wire
